// File: rtl/shifter_arb_pkg.sv
// Shared types and constants for the round-robin shifter arbiter.
// Optional rotate support is compiled in with SHIFTER_ARB_ROTATE_EN.
package shifter_arb_pkg;
  localparam int DATA_W  = 4;
  localparam int SHAMT_W = 2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Operand set captured at acceptance; requester inputs are never re-read.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    logic               dir;
`ifdef SHIFTER_ARB_ROTATE_EN
    logic               rot;
`endif
  } op_t;
endpackage

// File: rtl/shifter_arbiter_if.sv
// Request/response bus between requesters and the shifter arbiter.
// req_rot exists only when SHIFTER_ARB_ROTATE_EN is defined.
interface shifter_arbiter_if
  import shifter_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0][DATA_W-1:0]  req_data;
  logic [NREQ-1:0][SHAMT_W-1:0] req_shift;
  logic [NREQ-1:0]              req_dir;
`ifdef SHIFTER_ARB_ROTATE_EN
  logic [NREQ-1:0]              req_rot;
`endif
  logic [NREQ-1:0]              req_ready;
  logic                         resp_valid;
  logic [DATA_W-1:0]            resp_data;
  logic [IDW-1:0]               resp_id;
  logic                         resp_ready;

`ifdef SHIFTER_ARB_ROTATE_EN
  modport master (output req_valid, req_data, req_shift, req_dir, req_rot, resp_ready,
                  input  req_ready, resp_valid, resp_data, resp_id);
  modport slave  (input  req_valid, req_data, req_shift, req_dir, req_rot, resp_ready,
                  output req_ready, resp_valid, resp_data, resp_id);
`else
  modport master (output req_valid, req_data, req_shift, req_dir, resp_ready,
                  input  req_ready, resp_valid, resp_data, resp_id);
  modport slave  (input  req_valid, req_data, req_shift, req_dir, resp_ready,
                  output req_ready, resp_valid, resp_data, resp_id);
`endif
endinterface

// File: rtl/shift_core.sv
// Combinational 4-bit logical shifter; rotate path added under SHIFTER_ARB_ROTATE_EN.
module shift_core
  import shifter_arb_pkg::*;
(
  input  logic [DATA_W-1:0]  din,
  input  logic [SHAMT_W-1:0] amt,
  input  logic               dir,
`ifdef SHIFTER_ARB_ROTATE_EN
  input  logic               rot,
`endif
  output logic [DATA_W-1:0]  dout
);
  logic [DATA_W-1:0] shl, shr;

  assign shl = din << amt;
  assign shr = din >> amt;

`ifdef SHIFTER_ARB_ROTATE_EN
  logic [DATA_W-1:0] rol, ror;
  logic [2:0]        inv_amt;

  // amt = 0 gives inv_amt = 4, which shifts everything out and leaves din intact.
  assign inv_amt = 3'(DATA_W) - {1'b0, amt};
  assign rol     = shl | (din >> inv_amt);
  assign ror     = shr | (din << inv_amt);
  assign dout    = rot ? ((dir == DIR_RIGHT) ? ror : rol)
                       : ((dir == DIR_RIGHT) ? shr : shl);
`else
  assign dout = (dir == DIR_RIGHT) ? shr : shl;
`endif
endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sequencing one shared shift_core: IDLE grant, EXEC compute, RESP hold.
// Define SHIFTER_ARB_ROTATE_EN to add per-request rotate via req_rot.
module shifter_arbiter
  import shifter_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
)(
  input  logic                clk,
  input  logic                rst_n,
  shifter_arbiter_if.slave    bus,
  output logic                busy
);
  state_t            state, state_nx;
  logic [IDW-1:0]    last_grant, sel;
  logic              sel_vld, accept;
  op_t               op_q;
  logic [DATA_W-1:0] core_out;

  // First valid requester strictly after last_grant, wrapping.
  always_comb begin : arb
    int idx;
    sel_vld = 1'b0;
    sel     = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!sel_vld && bus.req_valid[idx]) begin
        sel_vld = 1'b1;
        sel     = IDW'(idx);
      end
    end
  end

  assign accept = rst_n && (state == IDLE) && sel_vld;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[sel] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sel_vld) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (bus.resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= IDW'(NREQ - 1);
      op_q          <= '0;
      bus.resp_data <= '0;
      bus.resp_id   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        last_grant <= sel;
        op_q.data  <= bus.req_data[sel];
        op_q.shamt <= bus.req_shift[sel];
        op_q.dir   <= bus.req_dir[sel];
`ifdef SHIFTER_ARB_ROTATE_EN
        op_q.rot   <= bus.req_rot[sel];
`endif
      end
      // last_grant still names the owner throughout EXEC.
      if (state == EXEC) begin
        bus.resp_data <= core_out;
        bus.resp_id   <= last_grant;
      end
    end
  end

  shift_core u_core (
    .din  (op_q.data),
    .amt  (op_q.shamt),
    .dir  (op_q.dir),
`ifdef SHIFTER_ARB_ROTATE_EN
    .rot  (op_q.rot),
`endif
    .dout (core_out)
  );

  assign bus.resp_valid = (state == RESP);
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: cycle-accurate reference model with a result scoreboard.
// Rotate steps run when SHIFTER_ARB_ROTATE_EN is defined.
module tb_shifter_arbiter;
  import shifter_arb_pkg::*;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  shifter_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus();

  shifter_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [3:0]     data;
  } exp_t;

  exp_t sb[$];
  int   cmp = 0;
  int   mis = 0;
  int   m_last = NREQ - 1;
  int   m_phase = 0;   // 0 idle, 1 exec, 2 resp
  bit   armed = 1'b0;

  function automatic logic [3:0] model_op(logic [3:0] d, int amt, logic dir, logic rot);
    logic [3:0] r;
    r = d;
    for (int k = 0; k < amt; k++) begin
      if (rot) r = dir ? {r[0], r[3:1]} : {r[2:0], r[3]};
      else     r = dir ? {1'b0, r[3:1]} : {r[2:0], 1'b0};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    cmp++;
    assert (got === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] d, input logic [1:0] sh,
                         input logic dir, input logic rot);
    bus.req_data[i]  = d;
    bus.req_shift[i] = sh;
    bus.req_dir[i]   = dir;
`ifdef SHIFTER_ARB_ROTATE_EN
    bus.req_rot[i]   = rot;
`else
    if (rot) $display("note: rotate requested without rotate support");
`endif
  endtask

  // Sample on the falling edge, compare against the model, then advance the model.
  task automatic tick();
    logic [NREQ-1:0] exp_rdy;
    logic            rot_i;
    int              g;
    @(negedge clk);
    if (armed) begin
      exp_rdy = '0;
      g = -1;
      if (rst_n && m_phase == 0 && |bus.req_valid) begin
        for (int k = 1; k <= NREQ; k++) begin
          int idx;
          idx = (m_last + k) % NREQ;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
        exp_rdy[g] = 1'b1;
      end
      chk("req_ready", 8'(bus.req_ready), 8'(exp_rdy));
      chk("resp_valid", 8'(bus.resp_valid), 8'(m_phase == 2));
      chk("busy", 8'(busy), 8'(m_phase != 0));
      if (m_phase == 2 && sb.size() > 0) begin
        chk("resp_data", 8'(bus.resp_data), 8'(sb[0].data));
        chk("resp_id", 8'(bus.resp_id), 8'(sb[0].id));
      end
      if (rst_n) begin
        case (m_phase)
          0: if (g >= 0) begin
`ifdef SHIFTER_ARB_ROTATE_EN
            rot_i = bus.req_rot[g];
`else
            rot_i = 1'b0;
`endif
            sb.push_back('{id: IDW'(g),
                           data: model_op(bus.req_data[g], int'(bus.req_shift[g]),
                                          bus.req_dir[g], rot_i)});
            m_last  = g;
            m_phase = 1;
          end
          1: m_phase = 2;
          default: if (bus.resp_ready) begin
            void'(sb.pop_front());
            m_phase = 0;
          end
        endcase
      end
    end
    if (!rst_n) begin
      armed   = 1'b1;
      m_phase = 0;
      m_last  = NREQ - 1;
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_shift  = '0;
    bus.req_dir    = '0;
`ifdef SHIFTER_ARB_ROTATE_EN
    bus.req_rot    = '0;
`endif
    bus.resp_ready = 1'b0;

    // Reset, including valid requests that must not be granted during reset.
    repeat (2) tick();
    bus.req_valid = '1;
    tick();
    chk("rst_resp_data", 8'(bus.resp_data), 8'h0);
    chk("rst_resp_id", 8'(bus.resp_id), 8'h0);
    chk("rst_resp_valid", 8'(bus.resp_valid), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    tick();

    // Basic left shift on requester 0.
    set_req(0, 4'b1101, 2'd1, DIR_LEFT, 1'b0);
    bus.req_valid[0] = 1'b1;
    tick();
    bus.req_valid = '0;
    repeat (3) tick();

    // Right shift, then pass-through in both directions, on requester 2.
    set_req(2, 4'b1101, 2'd2, DIR_RIGHT, 1'b0);
    bus.req_valid[2] = 1'b1;
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      set_req(2, 4'b1101, 2'd0, d[0], 1'b0);
      bus.req_valid[2] = 1'b1;
      tick();
      bus.req_valid = '0;
      repeat (3) tick();
    end

    // Reset while requester 3 is in EXEC: response is dropped, priority restarts at 0.
    set_req(3, 4'b0110, 2'd1, DIR_LEFT, 1'b0);
    bus.req_valid[3] = 1'b1;
    tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_resp_data", 8'(bus.resp_data), 8'h0);
    chk("mid_rst_resp_id", 8'(bus.resp_id), 8'h0);
    chk("mid_rst_busy", 8'(busy), 8'h0);
    rst_n = 1'b1;

    // Round robin: everyone valid, grants 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++)
      set_req(i, 4'($urandom), 2'($urandom), 1'($urandom), 1'b0);
    bus.req_valid = '1;
    repeat (15) tick();
    bus.req_valid = '0;
    repeat (3) tick();

    // Backpressure: response held while others clamour for a grant.
    bus.resp_ready = 1'b0;
    set_req(1, 4'b1011, 2'd3, DIR_LEFT, 1'b0);
    bus.req_valid[1] = 1'b1;
    tick();
    bus.req_valid = '1;
    repeat (7) tick();
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    repeat (2) tick();

`ifdef SHIFTER_ARB_ROTATE_EN
    for (int d = 0; d < 2; d++) begin
      set_req(0, 4'b1101, 2'd1, d[0], 1'b1);
      bus.req_valid[0] = 1'b1;
      tick();
      bus.req_valid = '0;
      repeat (3) tick();
    end
    set_req(0, 4'b1101, 2'd1, DIR_LEFT, 1'b0);
`endif

    // Random traffic with random backpressure and operands.
    repeat (120) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      bus.req_valid  = NREQ'($urandom);
      bus.resp_ready = 1'($urandom);
      tick();
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    repeat (4) tick();
    chk("sb_drained", 8'(sb.size()), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
